// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns the registered EX/MEM access into a valid/ready
// data-memory request, lane-aligns store data, extends load data and stalls EX/MEM meanwhile.
module mem_access_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read_m,
   input  logic        mem_write_m,
   input  logic [2:0]  func3_m,
   input  logic [63:0] addr_m,
   input  logic [63:0] wdata_m,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic        dmem_we,
   output logic [63:0] dmem_addr,
   output logic [63:0] dmem_wdata,
   output logic [7:0]  dmem_wstrb,
   input  logic        dmem_rsp_valid,
   input  logic [63:0] dmem_rdata,
   output logic        stall_m,
   output logic [63:0] load_data_m,
   output logic        misalign_m,
   output logic        bus_err_m
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int          CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW:0] CNT_ONE = (CW + 1)'(1);
   localparam logic [CW:0] CNT_LIM = (CW + 1)'(TIMEOUT);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    func3_q, func3_d;
   logic [2:0]    off_q, off_d;
   logic          we_q, we_d;
   logic [63:0]   addr_q, addr_d;
   logic [63:0]   wdata_q, wdata_d;
   logic [7:0]    wstrb_q, wstrb_d;
   logic [63:0]   load_data_q, load_data_d;
   logic          misalign_q, misalign_d;
   logic          bus_err_q, bus_err_d;

   logic          access, illegal, misaligned, legal;
   logic [7:0]    size_mask;
   logic [63:0]   shifted, load_ext;
   logic          sign_fill;
   logic [CW:0]   cnt_next;
   logic          timeout_hit;

   // Access classification; a simultaneous read and write is treated as a store.
   always_comb begin
      access  = mem_read_m | mem_write_m;
      illegal = mem_write_m ? func3_m[2] : (func3_m == 3'b111);
      case (func3_m[1:0])
         2'd0: begin size_mask = 8'h01; misaligned = 1'b0;           end
         2'd1: begin size_mask = 8'h03; misaligned = addr_m[0];      end
         2'd2: begin size_mask = 8'h0F; misaligned = |addr_m[1:0];   end
         default: begin size_mask = 8'hFF; misaligned = |addr_m[2:0]; end
      endcase
      legal = access & ~illegal & ~misaligned;
   end

   always_comb begin
      shifted   = dmem_rdata >> {off_q, 3'b000};
      sign_fill = ~func3_q[2];
      case (func3_q[1:0])
         2'd0:    load_ext = {{56{sign_fill & shifted[7]}},  shifted[7:0]};
         2'd1:    load_ext = {{48{sign_fill & shifted[15]}}, shifted[15:0]};
         2'd2:    load_ext = {{32{sign_fill & shifted[31]}}, shifted[31:0]};
         default: load_ext = shifted;
      endcase
   end

   // A handshake that lands on the last allowed cycle carries the counter one past the
   // limit, so the comparison is >= to guarantee WAIT still terminates.
   always_comb begin
      cnt_next    = {1'b0, cnt_q} + CNT_ONE;
      timeout_hit = (cnt_next >= CNT_LIM);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      func3_d     = func3_q;
      off_d       = off_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      load_data_d = load_data_q;
      misalign_d  = 1'b0;
      bus_err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (legal) begin
               func3_d = func3_m;
               off_d   = addr_m[2:0];
               we_d    = mem_write_m;
               addr_d  = {addr_m[63:3], 3'b000};
               wdata_d = wdata_m << {addr_m[2:0], 3'b000};
               wstrb_d = size_mask << addr_m[2:0];
               cnt_d   = '0;
               state_d = S_REQ;
            end else if (access) begin
               misalign_d = 1'b1;
            end
         end
         S_REQ: begin
            cnt_d = cnt_next[CW-1:0];
            if (dmem_req_ready) begin
               state_d = we_q ? S_DONE : S_WAIT;
            end else if (timeout_hit) begin
               bus_err_d   = 1'b1;
               load_data_d = '0;
               state_d     = S_DONE;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_next[CW-1:0];
            if (dmem_rsp_valid) begin
               load_data_d = load_ext;
               state_d     = S_DONE;
            end else if (timeout_hit) begin
               bus_err_d   = 1'b1;
               load_data_d = '0;
               state_d     = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         func3_q     <= '0;
         off_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         load_data_q <= '0;
         misalign_q  <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         func3_q     <= func3_d;
         off_q       <= off_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         load_data_q <= load_data_d;
         misalign_q  <= misalign_d;
         bus_err_q   <= bus_err_d;
      end
   end

   // The pipeline stall must also be low while reset is held, even if an access is presented.
   assign stall_m        = ~reset & ((state_q == S_REQ) | (state_q == S_WAIT) |
                                     ((state_q == S_IDLE) & legal));
   assign dmem_req_valid = (state_q == S_REQ);
   assign dmem_we        = we_q;
   assign dmem_addr      = addr_q;
   assign dmem_wdata     = wdata_q;
   assign dmem_wstrb     = wstrb_q;
   assign load_data_m    = load_data_q;
   assign misalign_m     = misalign_q;
   assign bus_err_m      = bus_err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table, randomized accesses against a
// byte-level reference model, and hand-written timeout / reset-in-flight sequences.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read_m, mem_write_m;
   logic [2:0]  func3_m;
   logic [63:0] addr_m, wdata_m;
   logic        dmem_req_ready, dmem_rsp_valid;
   logic [63:0] dmem_rdata;

   logic        dmem_req_valid, dmem_we, stall_m, misalign_m, bus_err_m;
   logic [63:0] dmem_addr, dmem_wdata, load_data_m;
   logic [7:0]  dmem_wstrb;

   logic        to_req_valid, to_we, to_stall, to_misalign, to_bus_err;
   logic [63:0] to_addr, to_wdata, to_load_data;
   logic [7:0]  to_wstrb;

   int total = 0;
   int bad   = 0;
   int txn_no = 0;
   logic [63:0] ld_model = '0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      int          rdy;
      int          rsp;
      logic        exp_req;
      logic        exp_mis;
      logic [63:0] exp_addr;
      logic [7:0]  exp_wstrb;
      logic [63:0] exp_wdata;
      logic [63:0] exp_ld;
      int          exp_stall;
   } txn_t;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .reset(reset),
      .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .func3_m(func3_m),
      .addr_m(addr_m), .wdata_m(wdata_m),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_wstrb(dmem_wstrb), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
      .stall_m(stall_m), .load_data_m(load_data_m),
      .misalign_m(misalign_m), .bus_err_m(bus_err_m)
   );

   mem_access_unit #(.TIMEOUT(4)) u_to (
      .clk(clk), .reset(reset),
      .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .func3_m(func3_m),
      .addr_m(addr_m), .wdata_m(wdata_m),
      .dmem_req_valid(to_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_we(to_we), .dmem_addr(to_addr), .dmem_wdata(to_wdata),
      .dmem_wstrb(to_wstrb), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
      .stall_m(to_stall), .load_data_m(to_load_data),
      .misalign_m(to_misalign), .bus_err_m(to_bus_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: works byte by byte from the access rules, independent of any shifter.
   function automatic txn_t fill_exp(input txn_t t, input logic [63:0] prev_ld);
      int sz, off;
      logic acc, bad_f3, mis;
      logic [15:0] m;
      logic [63:0] v;
      sz     = 1 << t.f3[1:0];
      off    = int'(t.addr[2:0]);
      acc    = t.rd | t.wr;
      bad_f3 = t.wr ? (t.f3 >= 3'd4) : (t.f3 == 3'd7);
      mis    = acc && (bad_f3 || ((t.addr % 64'(sz)) != 64'd0));
      t.exp_req   = acc && !mis;
      t.exp_mis   = mis;
      t.exp_addr  = t.addr & ~64'h7;
      m           = ((16'd1 << sz) - 16'd1) << off;
      t.exp_wstrb = m[7:0];
      t.exp_wdata = t.wdata << (8 * off);
      v = '0;
      if (t.exp_req) begin
         for (int i = 0; i < sz; i++) v = v | (64'(t.rdata[8*(off+i) +: 8]) << (8 * i));
         if (!t.f3[2] && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8 * sz));
      end
      t.exp_ld    = (t.exp_req && !t.wr) ? v : prev_ld;
      t.exp_stall = !t.exp_req ? 0 : (t.wr ? 2 + t.rdy : 2 + t.rdy + t.rsp);
      return t;
   endfunction

   // Acts as EX/MEM register plus memory: holds the access until stall_m is low at an edge.
   task automatic run_txn(input txn_t t);
      int stall_cnt = 0, req_cnt = 0, wait_cnt = 0;
      bit hs = 0, seen_req = 0, done = 0;
      mem_read_m  = t.rd;
      mem_write_m = t.wr;
      func3_m     = t.f3;
      addr_m      = t.addr;
      wdata_m     = t.wdata;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         dmem_req_ready = 1'b0;
         dmem_rsp_valid = 1'b0;
         dmem_rdata     = ~t.rdata;
         #1;
         if (dmem_req_valid) begin
            seen_req = 1;
            req_cnt++;
            if (t.exp_req) begin
               chk("req_we",    64'(dmem_we),    64'(t.wr));
               chk("req_addr",  dmem_addr,       t.exp_addr);
               chk("req_wstrb", 64'(dmem_wstrb), 64'(t.exp_wstrb));
               chk("req_wdata", dmem_wdata,      t.exp_wdata);
            end
            if (req_cnt > t.rdy) begin
               dmem_req_ready = 1'b1;
               hs = 1;
            end
         end else if (hs && !t.wr && stall_m) begin
            wait_cnt++;
            if (wait_cnt == t.rsp) begin
               dmem_rsp_valid = 1'b1;
               dmem_rdata     = t.rdata;
            end
         end
         if (stall_m) begin
            stall_cnt++;
         end else begin
            done = 1;
            chk("load_data",   load_data_m,       t.exp_ld);
            chk("bus_err_low", 64'(bus_err_m),    64'd0);
            chk("stall_cnt",   64'(stall_cnt),    64'(t.exp_stall));
            chk("req_seen",    64'(seen_req),     64'(t.exp_req));
         end
         @(posedge clk);
         #1;
      end
      if (!done) chk("txn_finished", 64'd0, 64'd1);
      chk("misalign", 64'(misalign_m), 64'(t.exp_mis));
      mem_read_m     = 1'b0;
      mem_write_m    = 1'b0;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      ld_model       = t.exp_ld;
      $display("txn %0d: rd=%0d wr=%0d f3=%0d addr=%h stall=%0d ld=%h", txn_no, t.rd, t.wr,
               t.f3, t.addr, stall_cnt, load_data_m);
      txn_no++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_read_m = 1'b0;
      mem_write_m = 1'b0;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      ld_model = '0;
   endtask

   txn_t tbl [13];
   txn_t t;

   initial begin
      tbl[0]  = '{0,1,3'd3,64'h1000,64'h1122334455667788,64'h0,0,1, 1,0,64'h1000,8'hFF,64'h1122334455667788,64'h0,2};
      tbl[1]  = '{0,1,3'd0,64'h1005,64'hAB,64'h0,0,1, 1,0,64'h1000,8'h20,64'h0000AB0000000000,64'h0,2};
      tbl[2]  = '{1,0,3'd0,64'h2003,64'h0,64'h80000000,0,1, 1,0,64'h2000,8'h08,64'h0,64'hFFFFFFFFFFFFFF80,3};
      tbl[3]  = '{1,0,3'd4,64'h2003,64'h0,64'h80000000,0,1, 1,0,64'h2000,8'h08,64'h0,64'h80,3};
      tbl[4]  = '{1,0,3'd2,64'h2002,64'h0,64'h0,0,1, 0,1,64'h0,8'h00,64'h0,64'h80,0};
      tbl[5]  = '{1,0,3'd3,64'h3008,64'h0,64'h0123456789ABCDEF,3,2, 1,0,64'h3008,8'hFF,64'h0,64'h0123456789ABCDEF,7};
      tbl[6]  = '{1,0,3'd1,64'h4006,64'h0,64'h8765000000000000,1,1, 1,0,64'h4000,8'hC0,64'h0,64'hFFFFFFFFFFFF8765,4};
      tbl[7]  = '{1,0,3'd6,64'h4004,64'h0,64'hF000000100000000,0,3, 1,0,64'h4000,8'hF0,64'h0,64'h00000000F0000001,5};
      tbl[8]  = '{1,0,3'd7,64'h5000,64'h0,64'h0,0,1, 0,1,64'h0,8'h00,64'h0,64'h00000000F0000001,0};
      tbl[9]  = '{1,1,3'd2,64'h6004,64'hDEADBEEFCAFEF00D,64'h0,2,1, 1,0,64'h6000,8'hF0,64'hCAFEF00D00000000,64'h00000000F0000001,4};
      tbl[10] = '{0,1,3'd5,64'h7002,64'h1234,64'h0,0,1, 0,1,64'h0,8'h00,64'h0,64'h00000000F0000001,0};
      tbl[11] = '{0,1,3'd1,64'h7003,64'h1234,64'h0,0,1, 0,1,64'h0,8'h00,64'h0,64'h00000000F0000001,0};
      tbl[12] = '{0,1,3'd1,64'h7006,64'h1234,64'h0,1,1, 1,0,64'h7000,8'hC0,64'h1234000000000000,64'h00000000F0000001,3};

      reset = 1'b1;
      mem_read_m = 1'b0; mem_write_m = 1'b0; func3_m = '0; addr_m = '0; wdata_m = '0;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_valid", 64'(dmem_req_valid), 64'd0);
      chk("rst_we",        64'(dmem_we),        64'd0);
      chk("rst_addr",      dmem_addr,           64'd0);
      chk("rst_wdata",     dmem_wdata,          64'd0);
      chk("rst_wstrb",     64'(dmem_wstrb),     64'd0);
      chk("rst_stall",     64'(stall_m),        64'd0);
      chk("rst_load_data", load_data_m,         64'd0);
      chk("rst_misalign",  64'(misalign_m),     64'd0);
      chk("rst_bus_err",   64'(bus_err_m),      64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      foreach (tbl[i]) run_txn(tbl[i]);

      for (int n = 0; n < 150; n++) begin
         t = tbl[0];
         t.rd    = 1'($urandom_range(0, 1));
         t.wr    = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) != 0 && !t.rd && !t.wr) t.rd = 1'b1;
         t.f3    = 3'($urandom_range(0, 7));
         t.addr  = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) t.addr = t.addr & ~((64'd1 << t.f3[1:0]) - 64'd1);
         t.wdata = {$urandom, $urandom};
         t.rdata = {$urandom, $urandom};
         t.rdy   = $urandom_range(0, 3);
         t.rsp   = $urandom_range(1, 3);
         t = fill_exp(t, ld_model);
         run_txn(t);
      end

      // Timeout: TIMEOUT=4 instance, load never accepted.
      do_reset();
      run_txn(tbl[3]);
      chk("to_pre_ld", to_load_data, 64'h80);
      begin
         int req = 0;
         bit found = 0;
         mem_read_m = 1'b1; mem_write_m = 1'b0; func3_m = 3'd3; addr_m = 64'h8000;
         dmem_req_ready = 1'b0;
         for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            #1;
            if (to_req_valid) req++;
            if (to_bus_err) begin
               found = 1;
               chk("to_load_zero", to_load_data, 64'd0);
               chk("to_stall_done", 64'(to_stall), 64'd0);
            end else begin
               @(posedge clk);
               #1;
            end
         end
         chk("to_bus_err_seen", 64'(found), 64'd1);
         chk("to_req_cycles",   64'(req),   64'd4);
         mem_read_m = 1'b0;
         @(posedge clk);
         #1;
         chk("to_bus_err_pulse", 64'(to_bus_err), 64'd0);
         $display("txn %0d: timeout sequence req_cycles=%0d", txn_no, req);
         txn_no++;
      end

      // Reset asserted while a load is in WAIT.
      do_reset();
      run_txn(tbl[6]);
      mem_read_m = 1'b1; mem_write_m = 1'b0; func3_m = 3'd3; addr_m = 64'h9000;
      @(posedge clk);
      #1;
      chk("rw_req", 64'(dmem_req_valid), 64'd1);
      dmem_req_ready = 1'b1;
      @(posedge clk);
      #1;
      dmem_req_ready = 1'b0;
      chk("rw_in_wait_stall", 64'(stall_m),        64'd1);
      chk("rw_in_wait_req",   64'(dmem_req_valid), 64'd0);
      #2;
      reset = 1'b1;
      #1;
      chk("rw_req_valid", 64'(dmem_req_valid), 64'd0);
      chk("rw_stall",     64'(stall_m),        64'd0);
      chk("rw_we",        64'(dmem_we),        64'd0);
      chk("rw_addr",      dmem_addr,           64'd0);
      chk("rw_wdata",     dmem_wdata,          64'd0);
      chk("rw_wstrb",     64'(dmem_wstrb),     64'd0);
      chk("rw_load_data", load_data_m,         64'd0);
      mem_read_m = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      dmem_rsp_valid = 1'b1;
      dmem_rdata     = ~64'd0;
      @(posedge clk);
      #1;
      dmem_rsp_valid = 1'b0;
      chk("rw_rsp_ignored", load_data_m,         64'd0);
      chk("rw_idle_stall",  64'(stall_m),        64'd0);
      chk("rw_idle_req",    64'(dmem_req_valid), 64'd0);
      $display("txn %0d: reset-in-wait sequence", txn_no);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
